// File: rtl/tx_uart.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Bit-compatible with rx_uart; every output is driven straight from a register.
module tx_uart #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_tx,
  input  logic [7:0] data_tx,
  input  logic       tx_start,
  output logic       out_serial_tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [7:0] DataMask = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0] DataLast = 3'(DATA_BITS - 1);
  localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            r_state;
  logic [BaudW-1:0]  r_baud_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic              r_parity;

  logic [7:0]        w_data;
  logic              w_baud_tc;

  // Bits above DATA_BITS-1 are dropped before they reach the shifter or the parity.
  assign w_data    = data_tx & DataMask;
  assign w_baud_tc = (r_baud_cnt == BaudLast);

  always_ff @(posedge clk or posedge rst_tx) begin
    if (rst_tx) begin
      r_state       <= StIdle;
      r_baud_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      out_serial_tx <= 1'b1;
      tx_busy       <= 1'b0;
      tx_done       <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (r_state == StIdle) begin
        out_serial_tx <= 1'b1;
        tx_busy       <= 1'b0;
        r_baud_cnt    <= '0;
        r_bit_cnt     <= '0;
        if (tx_start) begin
          r_shift       <= w_data;
          r_parity      <= (^w_data) ^ PARITY_ODD;
          r_state       <= StStart;
          tx_busy       <= 1'b1;
          out_serial_tx <= 1'b0;
        end
      end else if (!w_baud_tc) begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end else begin
        r_baud_cnt <= '0;
        case (r_state)
          StStart: begin
            r_state       <= StData;
            r_bit_cnt     <= '0;
            out_serial_tx <= r_shift[0];
          end
          StData: begin
            r_shift <= r_shift >> 1;
            if (r_bit_cnt == DataLast) begin
              r_bit_cnt <= '0;
              if (PARITY_EN) begin
                r_state       <= StParity;
                out_serial_tx <= r_parity;
              end else begin
                r_state       <= StStop;
                out_serial_tx <= 1'b1;
              end
            end else begin
              r_bit_cnt     <= r_bit_cnt + 1'b1;
              out_serial_tx <= r_shift[1];
            end
          end
          StParity: begin
            r_state       <= StStop;
            out_serial_tx <= 1'b1;
          end
          StStop: begin
            if (r_bit_cnt == StopLast) begin
              r_state   <= StIdle;
              r_bit_cnt <= '0;
              tx_busy   <= 1'b0;
              tx_done   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_uart.sv
// Bench for tx_uart: four parameterisations checked cycle by cycle against a frame model
// built from the bit list (start, data, parity, stops), plus a mid-bit receiver decode.
module tb_tx_uart;

  localparam int CPB   [4] = '{4, 1, 1, 2};
  localparam int DBITS [4] = '{8, 8, 8, 5};
  localparam int PEN   [4] = '{0, 1, 1, 1};
  localparam int PODD  [4] = '{0, 0, 1, 0};
  localparam int SB    [4] = '{1, 2, 2, 1};

  logic       clk;
  logic       rst;
  logic [7:0] r_data;
  logic [3:0] r_start;
  logic [3:0] w_line;
  logic [3:0] w_busy;
  logic [3:0] w_done;

  int n_vec;
  int n_err;

  tx_uart #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
            .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_tx(rst), .data_tx(r_data), .tx_start(r_start[0]),
    .out_serial_tx(w_line[0]), .tx_busy(w_busy[0]), .tx_done(w_done[0])
  );
  tx_uart #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
            .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_tx(rst), .data_tx(r_data), .tx_start(r_start[1]),
    .out_serial_tx(w_line[1]), .tx_busy(w_busy[1]), .tx_done(w_done[1])
  );
  tx_uart #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1),
            .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_tx(rst), .data_tx(r_data), .tx_start(r_start[2]),
    .out_serial_tx(w_line[2]), .tx_busy(w_busy[2]), .tx_done(w_done[2])
  );
  tx_uart #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
            .STOP_BITS(1)) dut3 (
    .clk(clk), .rst_tx(rst), .data_tx(r_data), .tx_start(r_start[3]),
    .out_serial_tx(w_line[3]), .tx_busy(w_busy[3]), .tx_done(w_done[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] status(input int k);
    return {5'd0, w_line[k], w_busy[k], w_done[k]};
  endfunction

  // Called at a negedge; the frame is accepted on the following posedge.
  task automatic start_frame(input int k, input logic [7:0] d);
    r_data     = d;
    r_start[k] = 1'b1;
  endtask

  task automatic run_frame(input int k, input logic [7:0] d, input bit junk, input bit chain,
                           input logic [7:0] nd);
    bit         q[$];
    int         len;
    logic [7:0] mask;
    logic [7:0] rx;
    mask = 8'((1 << DBITS[k]) - 1);
    q.push_back(1'b0);
    for (int b = 0; b < DBITS[k]; b++) q.push_back(d[b]);
    if (PEN[k] != 0) q.push_back((($countones(d & mask) % 2) == 1) != (PODD[k] == 1));
    for (int s = 0; s < SB[k]; s++) q.push_back(1'b1);
    len = q.size() * CPB[k];
    rx  = 8'd0;
    @(posedge clk);
    @(negedge clk);
    r_start[k] = 1'b0;
    r_data     = 8'($urandom);
    for (int i = 0; i < len; i++) begin
      int bi;
      bi = i / CPB[k];
      check($sformatf("dut%0d_%02h_cyc%0d", k, d, i), status(k), {5'd0, q[bi], 2'b10});
      if (bi >= 1 && bi <= DBITS[k] && (i % CPB[k]) == CPB[k] / 2) rx[bi-1] = w_line[k];
      if (junk && i == len / 2) begin
        r_start[k] = 1'b1;
        r_data     = 8'hFF;
      end
      if (junk && i == len / 2 + 2) r_start[k] = 1'b0;
      @(negedge clk);
    end
    check($sformatf("dut%0d_%02h_done", k, d), status(k), 8'b101);
    check($sformatf("dut%0d_%02h_rx", k, d), rx, d & mask);
    if (chain) begin
      start_frame(k, nd);
    end else begin
      @(negedge clk);
      check($sformatf("dut%0d_%02h_idle", k, d), status(k), 8'b100);
    end
  endtask

  task automatic check_idle(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      for (int k = 0; k < 4; k++) check($sformatf("%s_dut%0d_%0d", tag, k, c), status(k), 8'b100);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] nd;
    bit         ch;
    n_vec   = 0;
    n_err   = 0;
    rst     = 1'b1;
    r_start = 4'd0;
    r_data  = 8'd0;

    repeat (2) @(negedge clk);
    check_idle("in_reset", 1);
    rst = 1'b0;
    check_idle("idle", 20);

    start_frame(0, 8'hA5);  run_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00);
    start_frame(1, 8'hA5);  run_frame(1, 8'hA5, 1'b0, 1'b0, 8'h00);
    start_frame(1, 8'h01);  run_frame(1, 8'h01, 1'b0, 1'b0, 8'h00);
    start_frame(2, 8'hA5);  run_frame(2, 8'hA5, 1'b0, 1'b0, 8'h00);
    start_frame(2, 8'h01);  run_frame(2, 8'h01, 1'b0, 1'b0, 8'h00);
    start_frame(3, 8'hE0);  run_frame(3, 8'hE0, 1'b0, 1'b0, 8'h00);
    start_frame(3, 8'hFB);  run_frame(3, 8'hFB, 1'b0, 1'b0, 8'h00);

    start_frame(0, 8'h3C);  run_frame(0, 8'h3C, 1'b1, 1'b0, 8'h00);
    start_frame(1, 8'h3C);  run_frame(1, 8'h3C, 1'b1, 1'b0, 8'h00);
    check_idle("after_busy", 10);

    start_frame(0, 8'hA5);  run_frame(0, 8'hA5, 1'b0, 1'b1, 8'h5A);
    run_frame(0, 8'h5A, 1'b0, 1'b0, 8'h00);
    start_frame(1, 8'hA5);  run_frame(1, 8'hA5, 1'b0, 1'b1, 8'h5A);
    run_frame(1, 8'h5A, 1'b0, 1'b0, 8'h00);

    // Reset lands in data bit 3 of 8'hC3 (a 0 on the line) on the 4-clock DUT.
    start_frame(0, 8'hC3);
    @(posedge clk);
    @(negedge clk);
    r_start[0] = 1'b0;
    repeat (16) @(negedge clk);
    check("pre_reset_bit3", status(0), 8'b010);
    rst = 1'b1;
    #1;
    check("async_reset", status(0), 8'b100);
    repeat (2) begin
      @(negedge clk);
      check("held_reset", status(0), 8'b100);
    end
    rst = 1'b0;
    check_idle("no_resume", 50);

    start_frame(0, 8'h00);  run_frame(0, 8'h00, 1'b0, 1'b1, 8'hFF);
    run_frame(0, 8'hFF, 1'b0, 1'b1, 8'h55);
    run_frame(0, 8'h55, 1'b0, 1'b0, 8'h00);

    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      start_frame(k, d);
      for (int n = 0; n < 8; n++) begin
        nd = 8'($urandom);
        ch = (n < 7) && ($urandom_range(0, 1) == 1);
        run_frame(k, d, ($urandom_range(0, 3) == 0), ch, nd);
        if (!ch && n < 7) start_frame(k, nd);
        d = nd;
      end
    end
    check_idle("final", 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tx_uart.md
Name: tx_uart

Overview:
- UART transmitter; the transmit-side counterpart of rx_uart on the BLE module serial link.
- Accepts a parallel byte through a start/busy/done handshake.
- Serialises the byte LSB-first on out_serial_tx as start bit, data bits, optional parity bit, and 1 or 2 stop bits.
- Frames are bit-compatible with rx_uart, so a loopback tx_uart -> rx_uart is the system-level check.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit; must be >= 1 (1 matches the existing rx_uart bench timing of one bit per clock).
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_tx  input  1  asynchronous, active-high reset.
- data_tx  input  8  byte to send; bits [DATA_BITS-1:0] are used.
- tx_start  input  1  request to send; sampled on a rising clk edge.
- out_serial_tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when the last stop bit completes.

Behaviour:
- Reset (asynchronous, immediate): out_serial_tx=1, tx_busy=0, tx_done=0, FSM=IDLE, bit counter=0, baud counter=0, shift register=0.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Line is high.
  - On an edge where tx_start=1 (tx_busy is 0 in IDLE): latch data_tx into the shift register, compute parity from the latched data, go to START, set tx_busy=1, drive out_serial_tx=0 at that same edge.
- Bit timing:
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1 and advances the bit on its terminal count.
- START -> DATA: the line carries shift[0] first; the register shifts right each bit period.
- DATA -> PARITY after DATA_BITS bits when PARITY_EN=1; otherwise DATA -> STOP.
- PARITY bit value:
  - Even: XOR of the data bits.
  - Odd: inverted XOR of the data bits.
- STOP:
  - Line is high for STOP_BITS*CLKS_PER_BIT cycles.
  - At the edge ending the last stop bit: FSM=IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Frame length: (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, measured from the accepting edge to the edge where tx_busy falls.
- tx_start while tx_busy=1 is ignored. data_tx changes after acceptance have no effect on the frame in flight.
- Back-to-back frames: tx_start=1 in the cycle where tx_done=1 (tx_busy=0) is accepted. The next start bit follows the last stop bit with no extra idle cycles.
- tx_start held high continuously sends the byte present on data_tx at each acceptance edge, as consecutive frames.
- Reset mid-frame: the line returns high at once and tx_done is not pulsed. The frame is abandoned and is not resumed after reset release.
- Unused data_tx bits above DATA_BITS-1 are ignored and do not affect parity.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst_tx=1 for 2 cycles, then release with tx_start=0 for 20 cycles.
  - Required: out_serial_tx=1, tx_busy=0, tx_done=0 throughout.
- Basic 8N1 frame:
  - Stimulus: CLKS_PER_BIT=4; pulse tx_start with data_tx=8'hA5.
  - Required: line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_busy high for 40 cycles; single tx_done pulse at the end.
- Parity and stop bits:
  - Stimulus: PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, CLKS_PER_BIT=1; send 8'hA5, then 8'h01.
  - Required for 8'hA5: parity bit 0, frame 12 cycles.
  - Required for 8'h01: parity bit 1.
  - With PARITY_ODD=1, both parity bits are inverted.
- Busy protection:
  - Stimulus: start 8'h3C, then mid-frame assert tx_start with data_tx=8'hFF and change data_tx.
  - Required: 8'h3C is transmitted intact; no second frame starts; exactly one tx_done pulse.
- Back-to-back frames:
  - Stimulus: assert tx_start in the tx_done cycle, with data_tx=8'h5A after 8'hA5.
  - Required: the 8'h5A start bit directly follows the 8'hA5 stop bit; two tx_done pulses exactly one frame apart.
- Reset mid-frame and loopback:
  - Stimulus: assert rst_tx during data bit 3.
  - Required: line goes high asynchronously, tx_busy=0, no tx_done pulse.
  - Loopback: with out_serial_tx connected to rx_uart in_serial_tx and matching timing, rx_uart data_rx equals each byte sent (8'h00, 8'hFF, 8'h55).
